gray2bin_pipe: RTL and testbench
================================

# gray2bin_pipe

Streaming Gray-to-binary decoder with a valid/ready handshake and one register stage. It is the receive-side counterpart of the team's 4-bit binary-to-Gray encoder: it reconstructs binary counts from Gray-coded values, for example pointers crossing a clock domain or encoder positions. An optional step checker flags decoded consecutive values that differ by more than one count.

## Interface
- WIDTH, 4: code width in bits; legal range 2..16.
- clk  in  1: single clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- gr  in  WIDTH: Gray-coded input value.
- in_valid  in  1: `gr` carries a beat.
- in_ready  out  1: block accepts a beat this cycle.
- bin  out  WIDTH: decoded binary value.
- out_valid  out  1: `bin` holds a beat.
- out_ready  in  1: consumer accepts a beat this cycle.
- step_err  out  1: the current output beat failed the step check.
- err_cnt  out  8: saturating count of step errors.

## Operation
- Decode rule, MSB first:
  - bin[WIDTH-1] = gr[WIDTH-1].
  - bin[i] = bin[i+1] ^ gr[i], for i = WIDTH-2 down to 0.
- A beat is accepted when in_valid && in_ready. Its decoded value is registered into `bin`, and out_valid is set.
- A beat is delivered when out_valid && out_ready.
- in_ready = !out_valid || out_ready. Full throughput is one beat per cycle.
- If a beat is delivered and no new beat is accepted in the same cycle, out_valid clears.
- While out_valid && !out_ready, `bin`, step_err and out_valid hold stable.
- Step check (only when compiled in):
  - On each accept, the block computes d = (new - prev) mod 2^WIDTH, where prev is the last accepted decoded value.
  - d is legal if it is 0, 1, or 2^WIDTH-1. This permits hold, +1, -1 and wrap-around (e.g. 15 -> 0 at WIDTH=4).
  - Any other d sets step_err for that output beat and increments err_cnt. err_cnt saturates at 255.
  - The first beat after reset is never flagged. A have_prev flag marks that prev is valid.
- Reset values:
  - out_valid = 0, bin = 0, step_err = 0, err_cnt = 0.
  - have_prev = 0, prev = 0.
  - in_ready is therefore 1 on the first cycle after reset.
- Reset mid-operation: any pending output beat is discarded, and the checker history is cleared.

## Timing
- Latency: 1 cycle from accept to out_valid.
- in_ready depends combinationally on out_ready. No other combinational path runs input to output.
- Simultaneous deliver and accept: the new beat replaces the old one in the same edge, and out_valid stays 1.
- rst has priority over every handshake in that cycle.

## Configuration
- GRAY_STEP_CHECK_EN defined:
  - The step checker, prev/have_prev and err_cnt are built.
  - step_err and err_cnt behave as described under Operation.
- GRAY_STEP_CHECK_EN undefined:
  - No checker logic is built.
  - step_err and err_cnt remain ports, tied to 0.
  - Decode path and handshake are unchanged.

## Structure
- Package gray_pkg holds:
  - GRAY_W_DEFAULT = 4;
  - ERR_CNT_W = 8;
  - function gray_to_bin (a WIDTH-generic XOR prefix);
  - function bin_to_gray, for benches.
- One sub-module, gray_step_chk. It holds prev, have_prev, the modular distance compare and the saturating err_cnt, and is instantiated only under GRAY_STEP_CHECK_EN.

## Test plan
- Exhaustive decode (WIDTH=4, out_ready=1), as Gray codes 0000..1111 are sent one per cycle:
  - each `bin` equals the binary value whose Gray code was sent, one cycle later;
  - e.g. gr 0110 -> bin 0100, and gr 1000 -> bin 1111.
- Backpressure:
  - gr=0011 is accepted, then out_ready is held 0 for 3 cycles. bin=0010 and out_valid=1 hold, and in_ready=0.
  - Releasing out_ready delivers the beat, and in_ready returns to 1 in the same cycle.
- Streaming: Gray count 0..15..0 with in_valid=1 and out_ready=1 yields one beat per cycle, with bin incrementing and wrapping 15 -> 0. With GRAY_STEP_CHECK_EN defined, step_err stays 0 throughout.
- Step error (GRAY_STEP_CHECK_EN defined): send gr 0001 (bin 1), then gr 0111 (bin 5).
  - The second beat has step_err=1 and err_cnt=1.
  - Repeating gr 0111 gives step_err=0.
- Saturation: 300 alternating bin 0/8 beats leave err_cnt at 255.
- Reset mid-stream: assert rst while out_valid=1.
  - Next cycle: out_valid=0, bin=0, err_cnt=0.
  - The first post-reset beat is never flagged, whatever its value.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared widths and Gray/binary conversion helpers for the Gray decode path.
// gray_to_bin is width-generic: zero-extended inputs decode correctly at any width up to GRAY_W_MAX.
package gray_pkg;

  localparam int unsigned GRAY_W_DEFAULT = 4;
  localparam int unsigned GRAY_W_MAX     = 16;
  localparam int unsigned ERR_CNT_W      = 8;

  // XOR prefix from the MSB down; leading zeros leave the low bits unaffected.
  function automatic logic [GRAY_W_MAX-1:0] gray_to_bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b = '0;
    b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
    for (int i = int'(GRAY_W_MAX) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_W_MAX-1:0] bin_to_gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_step_chk.sv
// Step checker: flags accepted values that move by more than one count (mod 2^WIDTH)
// from the previous accepted value, and keeps a saturating error count.
module gray_step_chk
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept_i,
  input  logic [WIDTH-1:0]     value_i,
  output logic                 step_err_c,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  logic [WIDTH-1:0]     prev_q, prev_d;
  logic                 have_prev_q, have_prev_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]     diff_c;
  logic                 legal_c;

  // Modular distance; hold, +1 and -1 (including wrap) are legal moves.
  always_comb begin
    diff_c     = value_i - prev_q;
    legal_c    = (diff_c == '0) || (diff_c == WIDTH'(1)) || (diff_c == '1);
    step_err_c = accept_i && have_prev_q && !legal_c;
  end

  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    err_cnt_d   = err_cnt_q;
    if (accept_i) begin
      prev_d      = value_i;
      have_prev_d = 1'b1;
      if (step_err_c && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/gray2bin_pipe.sv
// Streaming Gray-to-binary decoder, one register stage with valid/ready handshake.
// Optional step checker built when GRAY_STEP_CHECK_EN is defined; otherwise step_err/err_cnt are tied to 0.
module gray2bin_pipe
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gr,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic             out_valid_q, out_valid_d;
  logic             step_err_q, step_err_d;
  logic [WIDTH-1:0] dec_c;
  logic             accept_c;
  logic             deliver_c;
  logic             chk_err_c;

  always_comb begin
    dec_c     = WIDTH'(gray_to_bin(GRAY_W_MAX'(gr)));
    in_ready  = !out_valid_q || out_ready;
    accept_c  = in_valid && in_ready;
    deliver_c = out_valid_q && out_ready;
  end

`ifdef GRAY_STEP_CHECK_EN
  gray_step_chk #(
    .WIDTH(WIDTH)
  ) u_step_chk (
    .clk       (clk),
    .rst       (rst),
    .accept_i  (accept_c),
    .value_i   (dec_c),
    .step_err_c(chk_err_c),
    .err_cnt_o (err_cnt)
  );
`else
  assign chk_err_c = 1'b0;
  assign err_cnt   = '0;
`endif

  // Accept overrides deliver so a back-to-back beat replaces the old one in place.
  always_comb begin
    bin_d       = bin_q;
    out_valid_d = out_valid_q;
    step_err_d  = step_err_q;
    if (accept_c) begin
      bin_d       = dec_c;
      out_valid_d = 1'b1;
      step_err_d  = chk_err_c;
    end else if (deliver_c) begin
      out_valid_d = 1'b0;
      step_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q       <= '0;
      out_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      out_valid_q <= out_valid_d;
      step_err_q  <= step_err_d;
    end
  end

  assign bin       = bin_q;
  assign out_valid = out_valid_q;
  assign step_err  = step_err_q;

endmodule

// File: tb/tb_gray2bin_pipe.sv
// Directed bench for gray2bin_pipe (WIDTH=4): decode table, backpressure, streaming,
// step checker, saturation and mid-stream reset; checker expectations follow GRAY_STEP_CHECK_EN.
module tb_gray2bin_pipe;

  logic       clk;
  logic       rst;
  logic [3:0] gr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] bin;
  logic       out_valid;
  logic       out_ready;
  logic       step_err;
  logic [7:0] err_cnt;

  int n_vec;
  int n_err;

`ifdef GRAY_STEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  gray2bin_pipe #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .gr       (gr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .step_err (step_err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gr;
    logic [3:0] exp_bin;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    gr        = 4'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [3:0] g);
    gr        = g;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{4'b0000, 4'd0};
    vecs[1]  = '{4'b0001, 4'd1};
    vecs[2]  = '{4'b0010, 4'd3};
    vecs[3]  = '{4'b0011, 4'd2};
    vecs[4]  = '{4'b0100, 4'd7};
    vecs[5]  = '{4'b0101, 4'd6};
    vecs[6]  = '{4'b0110, 4'd4};
    vecs[7]  = '{4'b0111, 4'd5};
    vecs[8]  = '{4'b1000, 4'd15};
    vecs[9]  = '{4'b1001, 4'd14};
    vecs[10] = '{4'b1010, 4'd12};
    vecs[11] = '{4'b1011, 4'd13};
    vecs[12] = '{4'b1100, 4'd8};
    vecs[13] = '{4'b1101, 4'd9};
    vecs[14] = '{4'b1110, 4'd11};
    vecs[15] = '{4'b1111, 4'd10};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; gr = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bin", 32'(bin), 32'd0);
    check("rst_step_err", 32'(step_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Exhaustive decode, one code per cycle
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].gr);
      check("dec_valid", 32'(out_valid), 32'd1);
      check("dec_bin", 32'(bin), 32'(vecs[i].exp_bin));
    end

    // Backpressure
    do_reset();
    gr = 4'b0011; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    check("bp_in_ready_empty", 32'(in_ready), 32'd1);
    tick();
    gr = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      check("bp_hold_bin", 32'(bin), 32'd2);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Streaming Gray count 0..15..0
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      int b;
      b = k % 16;
      send(4'(b ^ (b >> 1)));
      check("str_valid", 32'(out_valid), 32'd1);
      check("str_bin", 32'(bin), 32'(b));
      check("str_step_err", 32'(step_err), 32'd0);
    end
    check("str_err_cnt", 32'(err_cnt), 32'd0);

    // Step error
    do_reset();
    send(4'b0001);
    check("se_first_bin", 32'(bin), 32'd1);
    check("se_first_flag", 32'(step_err), 32'd0);
    send(4'b0111);
    check("se_jump_bin", 32'(bin), 32'd5);
    check("se_jump_flag", 32'(step_err), 32'(CHK));
    check("se_jump_cnt", 32'(err_cnt), CHK ? 32'd1 : 32'd0);
    send(4'b0111);
    check("se_hold_flag", 32'(step_err), 32'd0);
    check("se_hold_cnt", 32'(err_cnt), CHK ? 32'd1 : 32'd0);

    // Saturation: 300 alternating 0/8 beats
    do_reset();
    for (int k = 0; k < 300; k++) begin
      send((k % 2 == 0) ? 4'b0000 : 4'b1100);
      if (k == 9) check("sat_mid_cnt", 32'(err_cnt), CHK ? 32'd9 : 32'd0);
    end
    check("sat_cnt", 32'(err_cnt), CHK ? 32'd255 : 32'd0);
    check("sat_last_bin", 32'(bin), 32'd8);

    // Reset mid-stream with a pending beat and a competing accept
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; gr = 4'b0110; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_bin", 32'(bin), 32'd0);
    check("mid_err_cnt", 32'(err_cnt), 32'd0);
    check("mid_step_err", 32'(step_err), 32'd0);
    send(4'b1100);
    check("post_first_bin", 32'(bin), 32'd8);
    check("post_first_flag", 32'(step_err), 32'd0);
    send(4'b1101);
    check("post_step_flag", 32'(step_err), 32'd0);
    send(4'b0000);
    check("post_jump_flag", 32'(step_err), 32'(CHK));
    check("post_jump_cnt", 32'(err_cnt), CHK ? 32'd1 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
